// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: ALU results win by default; LSU results wait
// in a FIFO, and a starvation counter forces the FIFO head through.
module rf_writeback #(
    parameter int LSU_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid_i,
    output logic                         alu_ready_o,
    input  logic [4:0]                   alu_rd_i,
    input  logic [31:0]                  alu_data_i,
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [4:0]                   lsu_rd_i,
    input  logic [31:0]                  lsu_data_i,
    output logic                         rf_wr_en_o,
    output logic [4:0]                   rf_rd_o,
    output logic [31:0]                  rf_wdata_o,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    output logic                         pend_rs1_o,
    output logic                         pend_rs2_o,
    output logic [$clog2(LSU_DEPTH):0]   lsu_count_o
);

    localparam int PW = $clog2(LSU_DEPTH);
    localparam int CW = $clog2(LSU_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(LSU_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    mem_rd_q   [LSU_DEPTH];
    logic [4:0]    mem_rd_d   [LSU_DEPTH];
    logic [31:0]   mem_data_q [LSU_DEPTH];
    logic [31:0]   mem_data_d [LSU_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_wr_en_q, rf_wr_en_d;
    logic [4:0]    rf_rd_q, rf_rd_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;

    logic fifo_empty_s;
    logic force_s;
    logic alu_fire_s;
    logic push_s;
    logic pop_s;
    logic fifo_hit1_s;
    logic fifo_hit2_s;

    // Handshakes and winner selection; ready signals look only at registered state
    always_comb begin
        fifo_empty_s = (count_q == {CW{1'b0}});
        lsu_ready_o  = (count_q != FULL_CNT);
        force_s      = (starve_q == STARVE_MAX) && !fifo_empty_s;
        alu_ready_o  = !force_s;
        alu_fire_s   = alu_valid_i && !force_s;
        push_s       = lsu_valid_i && lsu_ready_o;
        pop_s        = !alu_fire_s && !fifo_empty_s;
    end

    // Next-state for FIFO, starvation counter and the registered write port
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rf_wr_en_d = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;

        if (push_s) begin
            mem_rd_d[wr_ptr_q]   = lsu_rd_i;
            mem_data_d[wr_ptr_q] = lsu_data_i;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // rd==0 still takes the slot and updates rd/data, it just never writes
        if (alu_fire_s) begin
            rf_wr_en_d = (alu_rd_i != 5'd0);
            rf_rd_d    = alu_rd_i;
            rf_wdata_d = alu_data_i;
        end else if (pop_s) begin
            rf_wr_en_d = (mem_rd_q[rd_ptr_q] != 5'd0);
            rf_rd_d    = mem_rd_q[rd_ptr_q];
            rf_wdata_d = mem_data_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end else begin
            rf_wr_en_d = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_s || fifo_empty_s) begin
            starve_d = {SW{1'b0}};
        end else if (alu_fire_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Pending-write lookup over live FIFO entries plus the uncommitted output slot
    always_comb begin
        fifo_hit1_s = 1'b0;
        fifo_hit2_s = 1'b0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            logic [PW-1:0] idx;
            logic          live;
            idx  = rd_ptr_q + PW'(i);
            live = (CW'(i) < count_q);
            fifo_hit1_s = fifo_hit1_s | (live & (mem_rd_q[idx] == rs1_i));
            fifo_hit2_s = fifo_hit2_s | (live & (mem_rd_q[idx] == rs2_i));
        end
        pend_rs1_o = (rs1_i != 5'd0) &
                     (fifo_hit1_s | (rf_wr_en_q & (rf_rd_q == rs1_i)));
        pend_rs2_o = (rs2_i != 5'd0) &
                     (fifo_hit2_s | (rf_wr_en_q & (rf_rd_q == rs2_i)));
    end

    // State registers; reset discards any buffered LSU results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LSU_DEPTH; i++) begin
                mem_rd_q[i]   <= 5'd0;
                mem_data_q[i] <= 32'd0;
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            starve_q   <= {SW{1'b0}};
            rf_wr_en_q <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wr_en_o  = rf_wr_en_q;
    assign rf_rd_o     = rf_rd_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign lsu_count_o = count_q;

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Single-port writeback arbiter that drives the register-file write port (wr_en/rd/wdata) from two result producers.
- Producer 1 is the ALU pipe (single-cycle results). Producer 2 is the LSU/multi-cycle unit (variable latency, valid/ready).
- LSU results are buffered in a small FIFO. The ALU has priority, with an anti-starvation override.
- Pending-write flags let decode detect RAW hazards on results not yet committed.

Parameters:
- LSU_DEPTH, 4, LSU result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive ALU wins with FIFO non-empty before LSU is forced.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  ALU result accepted this cycle
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  32  ALU result
- lsu_valid_i  in  1  LSU result valid
- lsu_ready_o  out  1  LSU FIFO can accept
- lsu_rd_i  in  5  LSU destination register
- lsu_data_i  in  32  LSU result
- rf_wr_en_o  out  1  regfile write enable (registered)
- rf_rd_o  out  5  regfile destination (registered)
- rf_wdata_o  out  32  regfile write data (registered)
- rs1_i  in  5  decode source 1 query
- rs2_i  in  5  decode source 2 query
- pend_rs1_o  out  1  rs1 has an uncommitted write
- pend_rs2_o  out  1  rs2 has an uncommitted write
- lsu_count_o  out  $clog2(LSU_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock.
  - In reset, rf_wr_en_o=0, rf_rd_o=0, rf_wdata_o=0.
  - FIFO is emptied (lsu_count_o=0) and the starve counter is cleared (0).
  - Reset asserted mid-operation discards all buffered LSU results.
- lsu_ready_o = (count != LSU_DEPTH). It depends on registered count only, so a full FIFO deasserts ready even while popping.
- LSU push occurs when lsu_valid_i && lsu_ready_o.
- alu_ready_o = !force, where force = (starve_cnt == STARVE_LIMIT) && FIFO non-empty. ALU handshake occurs when alu_valid_i && alu_ready_o.
- Per-cycle selection:
  - If the ALU handshake occurs, the ALU wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head wins (pop).
  - Otherwise, no write.
- Latency: the winner appears on rf_* on the next clock edge (1 cycle). rf_wr_en_o is held for exactly 1 cycle per write.
- rd==0 results: consumed/popped normally, but rf_wr_en_o=0 for that slot; rf_rd_o/rf_wdata_o still update.
- Starve counter:
  - Increments when the ALU wins while the FIFO is non-empty (saturates at STARVE_LIMIT).
  - Resets to 0 on any FIFO pop or when the FIFO is empty.
  - When force=1, the FIFO head pops that cycle and the counter returns to 0.
- Simultaneous push and pop: count unchanged, and the new entry is placed behind the head. Pointers wrap modulo LSU_DEPTH.
- An LSU push into an empty FIFO is not eligible to pop in the same cycle (no fall-through). Minimum LSU latency is 2 cycles.
- Ordering: LSU results commit in arrival order. ALU and LSU results may interleave; producers guarantee no WAW between them.
- Pending flags (combinational):
  - pend_rsN_o=1 iff rsN!=0 and any valid FIFO entry has rd==rsN.
  - The current output slot (rf_wr_en_o && rf_rd_o==rsN) also sets the flag, since the regfile has not yet captured it.
  - Incoming alu_*/lsu_* are not considered.
- Write to rd X followed by a read of X from the regfile is valid from the cycle after rf_wr_en_o drops.

Test Plan:
- Reset release, no traffic -> rf_wr_en_o=0, lsu_ready_o=1, lsu_count_o=0, pend flags 0.
- ALU rd=5 data=0xDEADBEEF in cycle N -> rf_wr_en_o=1, rf_rd_o=5, rf_wdata_o=0xDEADBEEF in N+1 only; alu_rd_i=0 -> rf_wr_en_o stays 0.
- 4 LSU pushes (rd=1..4) with ALU valid every cycle:
  - lsu_ready_o=0 after the 4th push.
  - After 8 ALU wins, alu_ready_o=0 for one cycle and rd=1 is written.
  - Repeats until drained in order 1,2,3,4.
- FIFO full with simultaneous push attempt and pop -> push refused (ready=0), count 4->3; next cycle ready=1, push accepted, count 4.
- LSU rd=7 buffered, rs1_i=7 -> pend_rs1_o=1 until the cycle after its rf_wr_en_o pulse; rs2_i=0 -> pend_rs2_o=0.
- Assert rst_n low with 3 entries buffered -> outputs 0 immediately, count 0, no further writes after release.
